// File: rtl/data_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_slave_if
// Brief    : CPU data-port and write-trace bundle for data_mem_slave.
// Revision : 1.0
// ============================================================================
interface data_mem_slave_if #(
    parameter int TRACE_DEPTH = 8
);
    localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;

    logic [31:0]      m_data_addr;
    logic [31:0]      m_data_wdata;
    logic [3:0]       m_data_byteen;
    logic [31:0]      m_inst_addr;
    logic [31:0]      m_data_rdata;
    logic             trace_valid;
    logic             trace_ready;
    logic [31:0]      trace_pc;
    logic [31:0]      trace_addr;
    logic [31:0]      trace_data;
    logic [CNT_W-1:0] trace_count;
    logic             trace_overflow;
    logic             addr_err;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
               trace_count, trace_overflow, addr_err
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
               trace_count, trace_overflow, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_slave
// Brief    : Byte-enabled word data memory with a write-trace FIFO.
// Revision : 1.0
// ============================================================================
module data_mem_slave #(
    parameter int DEPTH_WORDS = 4096,
    parameter int TRACE_DEPTH = 8
) (
    input  wire              clk,
    input  wire              reset,
    data_mem_slave_if.slave  bus
);
    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam int          PW          = $clog2(TRACE_DEPTH);
    localparam int          CNT_W       = PW + 1;
    localparam logic [32:0] c_BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]      r_mem     [DEPTH_WORDS];
    logic [31:0]      r_fifo_pc [TRACE_DEPTH];
    logic [31:0]      r_fifo_ad [TRACE_DEPTH];
    logic [31:0]      r_fifo_dt [TRACE_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_addr_err;

    logic [AW-1:0]    w_idx;
    logic             w_in_range;
    logic [31:0]      w_old_word;
    logic [31:0]      w_merged;
    logic             w_any_be;
    logic             w_wr;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_idx      = bus.m_data_addr[AW+1:2];
    assign w_in_range = {1'b0, bus.m_data_addr} < c_BYTE_LIMIT;
    assign w_any_be   = |bus.m_data_byteen;
    assign w_wr       = w_any_be && w_in_range;

    always_comb begin
        w_old_word = '0;
        if (w_in_range)
            w_old_word = r_mem[w_idx];
    end

    always_comb begin
        w_merged = w_old_word;
        for (int i = 0; i < 4; i++)
            if (bus.m_data_byteen[i])
                w_merged[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
    end

    assign bus.m_data_rdata = w_old_word;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_W'(TRACE_DEPTH));
    assign w_pop   = w_valid && bus.trace_ready;
    assign w_push  = w_wr && (!w_full || w_pop);
    assign w_drop  = w_wr && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_fifo_pc[r_wr_ptr] <= bus.m_inst_addr;
            r_fifo_ad[r_wr_ptr] <= {bus.m_data_addr[31:2], 2'b00};
            r_fifo_dt[r_wr_ptr] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
            if (w_any_be && !w_in_range)
                r_addr_err <= 1'b1;
        end
    end

    assign bus.trace_valid    = w_valid;
    assign bus.trace_count    = r_count;
    assign bus.trace_pc       = w_valid ? r_fifo_pc[r_rd_ptr] : 32'd0;
    assign bus.trace_addr     = w_valid ? r_fifo_ad[r_rd_ptr] : 32'd0;
    assign bus.trace_data     = w_valid ? r_fifo_dt[r_rd_ptr] : 32'd0;
    assign bus.trace_overflow = r_overflow;
    assign bus.addr_err       = r_addr_err;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_slave
// Brief    : Directed self-checking bench for data_mem_slave.
// Revision : 1.0
// ============================================================================
module tb_data_mem_slave;
    localparam int DEPTH_WORDS = 4096;
    localparam int TRACE_DEPTH = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    data_mem_slave_if #(.TRACE_DEPTH(TRACE_DEPTH)) bus ();

    data_mem_slave #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One clock cycle with the given bus inputs; inputs return to idle after the edge.
    task automatic cycle(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] pc, input logic rdy);
        @(negedge clk);
        bus.m_data_addr   = addr;
        bus.m_data_wdata  = wdata;
        bus.m_data_byteen = be;
        bus.m_inst_addr   = pc;
        bus.trace_ready   = rdy;
        @(posedge clk);
        #1;
        bus.m_data_byteen = 4'b0000;
        bus.trace_ready   = 1'b0;
    endtask

    task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus.m_data_addr = addr;
        #1;
        check(tag, bus.m_data_rdata, exp);
    endtask

    task automatic pop();
        cycle(32'h0, 32'h0, 4'b0000, 32'h0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset             = 1'b0;
        bus.m_data_addr   = '0;
        bus.m_data_wdata  = '0;
        bus.m_data_byteen = '0;
        bus.m_inst_addr   = '0;
        bus.trace_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        check("rst_count", 32'(bus.trace_count), 32'd0);
        check("rst_valid", 32'(bus.trace_valid), 32'd0);
        check("rst_ovf",   32'(bus.trace_overflow), 32'd0);
        check("rst_err",   32'(bus.addr_err), 32'd0);
        check("rst_tpc",   bus.trace_pc, 32'd0);
        peek(32'h10, 32'h0, "rst_rdata");

        // Full-word write, then lane merge; rdata must show the pre-write word.
        @(negedge clk);
        bus.m_data_addr = 32'h10; bus.m_data_wdata = 32'h11223344;
        bus.m_data_byteen = 4'b1111; bus.m_inst_addr = 32'h3000;
        #1 check("rbw_rdata", bus.m_data_rdata, 32'h0);
        check("no_bypass", 32'(bus.trace_valid), 32'd0);
        @(posedge clk); #1 bus.m_data_byteen = 4'b0000;
        peek(32'h10, 32'h11223344, "wr_full_rdata");
        check("wr_full_cnt", 32'(bus.trace_count), 32'd1);
        check("wr_full_tpc", bus.trace_pc, 32'h3000);
        check("wr_full_tad", bus.trace_addr, 32'h10);
        check("wr_full_tdt", bus.trace_data, 32'h11223344);

        cycle(32'h10, 32'h0000AA00, 4'b0010, 32'h3004, 1'b0);
        peek(32'h10, 32'h1122AA44, "merge_rdata");
        cycle(32'h13, 32'h55000000, 4'b1000, 32'h3008, 1'b0);
        peek(32'h10, 32'h5522AA44, "b2b_rdata");
        pop();
        check("merge_tdt", bus.trace_data, 32'h1122AA44);
        check("merge_tpc", bus.trace_pc, 32'h3004);
        pop();
        check("b2b_tdt", bus.trace_data, 32'h5522AA44);
        check("b2b_tad", bus.trace_addr, 32'h10);
        pop();
        check("empty_cnt", 32'(bus.trace_count), 32'd0);
        check("empty_tdt", bus.trace_data, 32'd0);
        check("empty_tad", bus.trace_addr, 32'd0);
        pop();
        check("pop_empty_cnt", 32'(bus.trace_count), 32'd0);

        // Overflow: nine writes with no consumer.
        for (int i = 0; i < 9; i++)
            cycle(32'h100 + 32'(4*i), 32'hA0 + 32'(i), 4'b1111, 32'h1000 + 32'(4*i), 1'b0);
        check("ovf_cnt",  32'(bus.trace_count), 32'd8);
        check("ovf_flag", 32'(bus.trace_overflow), 32'd1);
        check("ovf_head", bus.trace_pc, 32'h1000);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_pc%0d", i), bus.trace_pc, 32'h1000 + 32'(4*i));
            check($sformatf("ovf_dt%0d", i), bus.trace_data, 32'hA0 + 32'(i));
            pop();
        end
        check("ovf_drain", 32'(bus.trace_count), 32'd0);
        check("ovf_sticky", 32'(bus.trace_overflow), 32'd1);

        // Reset clears flags, then full FIFO with simultaneous push and pop.
        cycle(32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        check("rst2_ovf", 32'(bus.trace_overflow), 32'd0);
        for (int i = 0; i < 8; i++)
            cycle(32'h200 + 32'(4*i), 32'hB0 + 32'(i), 4'b1111, 32'h2000 + 32'(4*i), 1'b0);
        cycle(32'h220, 32'hB8, 4'b1111, 32'h2020, 1'b1);
        check("fullpp_cnt", 32'(bus.trace_count), 32'd8);
        check("fullpp_ovf", 32'(bus.trace_overflow), 32'd0);
        for (int i = 1; i < 9; i++) begin
            check($sformatf("fullpp_pc%0d", i), bus.trace_pc, 32'h2000 + 32'(4*i));
            check($sformatf("fullpp_ad%0d", i), bus.trace_addr, 32'h200 + 32'(4*i));
            pop();
        end
        check("fullpp_drain", 32'(bus.trace_count), 32'd0);

        // Out-of-range write must not alias onto word 0.
        cycle(32'h0, 32'hCAFEF00D, 4'b1111, 32'h4000, 1'b1);
        pop();
        @(negedge clk);
        bus.m_data_addr = 32'h4000; bus.m_data_wdata = 32'h12345678;
        bus.m_data_byteen = 4'b1111; bus.m_inst_addr = 32'h5000;
        #1 check("oor_rdata", bus.m_data_rdata, 32'h0);
        @(posedge clk); #1 bus.m_data_byteen = 4'b0000;
        check("oor_err", 32'(bus.addr_err), 32'd1);
        check("oor_cnt", 32'(bus.trace_count), 32'd0);
        peek(32'h0, 32'hCAFEF00D, "oor_word0");
        peek(32'h3FFC, 32'h0, "oor_last");

        // Reset with pending entries and a concurrent write.
        cycle(32'h10, 32'h77, 4'b1111, 32'h6000, 1'b0);
        cycle(32'h14, 32'h88, 4'b1111, 32'h6004, 1'b0);
        cycle(32'h18, 32'h99, 4'b1111, 32'h6008, 1'b0);
        cycle(32'h1C, 32'hAA, 4'b1111, 32'h600C, 1'b0);
        cycle(32'h20, 32'hBB, 4'b1111, 32'h6010, 1'b0);
        cycle(32'h24, 32'hCC, 4'b1111, 32'h6014, 1'b0);
        cycle(32'h28, 32'hDD, 4'b1111, 32'h6018, 1'b0);
        cycle(32'h2C, 32'hEE, 4'b1111, 32'h601C, 1'b0);
        cycle(32'h30, 32'hFF, 4'b1111, 32'h6020, 1'b0);
        check("pre_rst_ovf", 32'(bus.trace_overflow), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.m_data_addr = 32'h10; bus.m_data_wdata = 32'h5A5A5A5A;
        bus.m_data_byteen = 4'b1111; bus.trace_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; bus.m_data_byteen = 4'b0000; bus.trace_ready = 1'b0;
        check("rst3_cnt",   32'(bus.trace_count), 32'd0);
        check("rst3_valid", 32'(bus.trace_valid), 32'd0);
        check("rst3_ovf",   32'(bus.trace_overflow), 32'd0);
        check("rst3_err",   32'(bus.addr_err), 32'd0);
        peek(32'h10, 32'h0, "rst3_rdata10");
        peek(32'h0, 32'h0, "rst3_rdata0");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/data_mem_slave.md
DATA_MEM_SLAVE -- requirements
Module: data_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, setting the memory size in 32-bit words (byte range 0 .. DEPTH_WORDS*4-1).
REQ-002 SHALL have parameter TRACE_DEPTH, default 8, setting the number of write-trace FIFO entries (power of two).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset, sampled on posedge clk.
REQ-005 SHALL have port m_data_addr, input, 32: CPU data byte address.
REQ-006 SHALL have port m_data_wdata, input, 32: write data, already lane-aligned by the CPU.
REQ-007 SHALL have port m_data_byteen, input, 4: per-byte write enable; 4'b0000 means no write.
REQ-008 SHALL have port m_inst_addr, input, 32: PC of the instruction issuing the access.
REQ-009 SHALL have port m_data_rdata, output, 32: full aligned word read at m_data_addr.
REQ-010 SHALL have port trace_valid, output, 1: trace FIFO head is valid.
REQ-011 SHALL have port trace_ready, input, 1: consumer accepts the head entry.
REQ-012 SHALL have port trace_pc, output, 32: PC of the head entry.
REQ-013 SHALL have port trace_addr, output, 32: word-aligned address of the head entry.
REQ-014 SHALL have port trace_data, output, 32: full word after merge for the head entry.
REQ-015 SHALL have port trace_count, output, log2(TRACE_DEPTH)+1: current FIFO occupancy.
REQ-016 SHALL have port trace_overflow, output, 1: sticky flag, set when a trace entry is dropped.
REQ-017 SHALL have port addr_err, output, 1: sticky flag, set by an out-of-range access.

Function
REQ-018 SHALL index memory by word index m_data_addr[31:2]; address bits [1:0] are ignored.
REQ-019 SHALL treat an address as in range when m_data_addr < DEPTH_WORDS*4.
REQ-020 SHALL drive m_data_rdata combinationally with the stored word at that index, showing contents from before any same-cycle write (read-before-write).
REQ-021 SHALL drive m_data_rdata as 0 when the address is out of range.
REQ-022 SHALL treat a write as accepted when byteen != 0 and the address is in range.
REQ-023 SHALL, on each accepted write at posedge, update byte lane i from m_data_wdata[8i+7:8i] only where byteen[i]=1; other lanes keep their value.
REQ-024 SHALL, on byteen != 0 with an out-of-range address: leave memory unchanged, push no trace entry, and set addr_err.
REQ-025 SHALL, on each accepted write, push one trace entry {m_inst_addr, {m_data_addr[31:2],2'b00}, merged word}; merged word = old word with the enabled lanes replaced.
REQ-026 SHALL pop on a posedge with trace_valid=1 and trace_ready=1; trace_ready is ignored while empty.
REQ-027 SHALL make trace_valid=1 exactly when trace_count != 0; trace_pc, trace_addr and trace_data hold the head entry and stay stable until popped.
REQ-028 SHALL, when full and pushing without a simultaneous pop, drop the new entry, set trace_overflow, and leave count unchanged.
REQ-029 SHALL, when full with simultaneous push and pop, accept both: count stays TRACE_DEPTH and no overflow.
REQ-030 SHALL, when empty and pushing, assert trace_valid on the next cycle; no same-cycle bypass.
REQ-031 SHALL let FIFO read and write pointers wrap modulo TRACE_DEPTH with no entry lost or duplicated.
REQ-032 SHALL, on back-to-back writes to the same word, make the second merge use the word produced by the first.

Reset
REQ-033 SHALL, when reset=0 at posedge, clear all memory words to 0, empty the FIFO (trace_count=0, trace_valid=0), and clear trace_overflow and addr_err.
REQ-034 SHALL give reset priority over any same-cycle write or pop; a write issued in the reset cycle is discarded and not traced.
REQ-035 SHALL drive trace_pc, trace_addr and trace_data as 0 while the FIFO is empty.

Verification
REQ-036 SHALL check: after reset, write addr 0x10, data 0x11223344, byteen 4'b1111, pc 0x3000 -> next cycle rdata@0x10=0x11223344; trace entry = {0x3000, 0x10, 0x11223344}.
REQ-037 SHALL check: with 0x11223344 stored at 0x10, write 0x0000AA00, byteen 4'b0010 -> word = 0x1122AA44; trace_data = 0x1122AA44.
REQ-038 SHALL check: 9 accepted writes with trace_ready=0 -> trace_count=8, trace_overflow=1, head = first write; 8 pops then return entries 1..8 in order.
REQ-039 SHALL check: FIFO full; push with trace_ready=1 in the same cycle -> count stays 8, no overflow, new entry appears last.
REQ-040 SHALL check: write addr 0x4000 (DEPTH_WORDS=4096), byteen 4'b1111 -> addr_err=1, rdata=0, no trace push, memory unchanged.
REQ-041 SHALL check: reset=0 driven during pending trace entries and a concurrent write -> next cycle count=0, both flags=0, rdata@0x10=0.
